// File: rtl/pc_seq_if.sv
// Bundle of the run-control signals between pc_seq_ctrl and the PC register, imem and decode/execute.
// Optional macro PC_SEQ_STEP_EN adds the single-step request step_i.
interface pc_seq_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
);
  logic             go_i;
  logic [XLEN-1:0]  pc_i;
  logic             fetch_req_o;
  logic             imem_ready_i;
  logic             ecall_i;
  logic             branch_taken_i;
  logic [XLEN-1:0]  branch_target_i;
  logic             pc_start_o;
  logic [XLEN-1:0]  pc_next_o;
  logic             busy_o;
  logic             halted_o;
  logic             error_o;
  logic [CNT_W-1:0] instr_cnt_o;
`ifdef PC_SEQ_STEP_EN
  logic             step_i;
`endif

  modport master (
`ifdef PC_SEQ_STEP_EN
    input  step_i,
`endif
    input  go_i, pc_i, imem_ready_i, ecall_i, branch_taken_i, branch_target_i,
    output fetch_req_o, pc_start_o, pc_next_o, busy_o, halted_o, error_o, instr_cnt_o
  );

  modport slave (
`ifdef PC_SEQ_STEP_EN
    output step_i,
`endif
    output go_i, pc_i, imem_ready_i, ecall_i, branch_taken_i, branch_target_i,
    input  fetch_req_o, pc_start_o, pc_next_o, busy_o, halted_o, error_o, instr_cnt_o
  );
endinterface

// File: rtl/pc_seq_ctrl.sv
// Program-counter run-control sequencer: fetch handshake, branch redirect, ecall halt, fetch timeout.
// Optional macro PC_SEQ_STEP_EN enables single-step (EXEC returns to IDLE when step_i is set).
module pc_seq_ctrl #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 32
) (
  input  logic     clk,
  input  logic     reset,
  pc_seq_if.master bus
);
  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_HALT,
    S_ERROR
  } state_t;

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_t           state_reg, state_next;
  logic [7:0]       wait_reg, wait_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [CNT_W-1:0] cnt_inc;
  logic [XLEN-1:0]  pc_plus4;
  logic [XLEN-1:0]  target_aligned;
`ifdef PC_SEQ_STEP_EN
  logic             resume_reg, resume_next;
`endif

  assign pc_plus4        = bus.pc_i + XLEN'(4);
  assign target_aligned  = {bus.branch_target_i[XLEN-1:2], 2'b00};
  assign cnt_inc         = (&cnt_reg) ? cnt_reg : cnt_reg + CNT_W'(1);
  assign bus.instr_cnt_o = cnt_reg;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg  <= S_IDLE;
      wait_reg   <= '0;
      cnt_reg    <= '0;
`ifdef PC_SEQ_STEP_EN
      resume_reg <= 1'b0;
`endif
    end else begin
      state_reg  <= state_next;
      wait_reg   <= wait_next;
      cnt_reg    <= cnt_next;
`ifdef PC_SEQ_STEP_EN
      resume_reg <= resume_next;
`endif
    end
  end

  always_comb begin
    state_next      = state_reg;
    wait_next       = wait_reg;
    cnt_next        = cnt_reg;
`ifdef PC_SEQ_STEP_EN
    resume_next     = resume_reg;
`endif
    bus.fetch_req_o = 1'b0;
    bus.pc_start_o  = 1'b0;
    bus.pc_next_o   = '0;
    bus.busy_o      = 1'b0;
    bus.halted_o    = 1'b0;
    bus.error_o     = 1'b0;

    case (state_reg)
      S_IDLE: begin
        if (bus.go_i) begin
          state_next = S_FETCH;
          wait_next  = '0;
`ifdef PC_SEQ_STEP_EN
          // A single-step pause resumes with the count intact.
          if (!resume_reg) cnt_next = '0;
          resume_next = 1'b0;
`else
          cnt_next   = '0;
`endif
        end
      end

      S_FETCH: begin
        bus.fetch_req_o = 1'b1;
        bus.busy_o      = 1'b1;
        // Ready takes precedence over the timeout on the final wait cycle.
        if (bus.imem_ready_i) begin
          state_next = S_EXEC;
          wait_next  = '0;
        end else if (wait_reg == WAIT_LAST) begin
          state_next = S_ERROR;
          wait_next  = '0;
        end else begin
          wait_next  = wait_reg + 8'd1;
        end
      end

      S_EXEC: begin
        bus.busy_o    = 1'b1;
        bus.pc_next_o = bus.branch_taken_i ? target_aligned : pc_plus4;
        cnt_next      = cnt_inc;
        if (bus.ecall_i) begin
          state_next = S_HALT;
        end else begin
          bus.pc_start_o = 1'b1;
`ifdef PC_SEQ_STEP_EN
          if (bus.step_i) begin
            state_next  = S_IDLE;
            resume_next = 1'b1;
          end else begin
            state_next  = S_FETCH;
          end
`else
          state_next = S_FETCH;
`endif
        end
      end

      S_HALT: begin
        bus.halted_o = 1'b1;
        // Leaving HALT skips past the ecall with a single PC load.
        if (bus.go_i) begin
          bus.pc_start_o = 1'b1;
          bus.pc_next_o  = pc_plus4;
          state_next     = S_FETCH;
          wait_next      = '0;
        end
      end

      S_ERROR: begin
        bus.error_o = 1'b1;
        if (bus.go_i) state_next = S_IDLE;
      end

      default: state_next = S_IDLE;
    endcase
  end
endmodule

// File: tb/tb_pc_seq_ctrl.sv
// Self-checking bench for pc_seq_ctrl: directed scenarios followed by randomized traffic against a cycle model.
module tb_pc_seq_ctrl;
  localparam int XLEN    = 32;
  localparam int TIMEOUT = 15;
  localparam int CNT_W   = 4;
  localparam longint CNT_MAX = (64'd1 << CNT_W) - 1;

  localparam int M_IDLE  = 0;
  localparam int M_FETCH = 1;
  localparam int M_EXEC  = 2;
  localparam int M_HALT  = 3;
  localparam int M_ERROR = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pc_seq_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();

  pc_seq_ctrl #(.XLEN(XLEN), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  // Reference state: PC register contents plus the sequencer model.
  logic [31:0] pc;
  int          m_mode;
  int          m_wait;
  longint      m_cnt;
  logic        exp_start;
  logic [31:0] exp_next;
  bit          verbose;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic compare_model();
    exp_start = 1'b0;
    exp_next  = 32'h0;
    if (m_mode == M_EXEC) begin
      exp_start = !bus.ecall_i;
      exp_next  = bus.branch_taken_i ? (bus.branch_target_i & 32'hFFFF_FFFC) : pc + 32'd4;
    end else if (m_mode == M_HALT && bus.go_i) begin
      exp_start = 1'b1;
      exp_next  = pc + 32'd4;
    end
    chk("fetch_req", bus.fetch_req_o, m_mode == M_FETCH);
    chk("busy",      bus.busy_o,      m_mode == M_FETCH || m_mode == M_EXEC);
    chk("halted",    bus.halted_o,    m_mode == M_HALT);
    chk("error",     bus.error_o,     m_mode == M_ERROR);
    chk("pc_start",  bus.pc_start_o,  exp_start);
    chk("pc_next",   bus.pc_next_o,   exp_next);
    chk("instr_cnt", bus.instr_cnt_o, m_cnt);
    if (verbose && m_mode == M_EXEC)
      $display("exec pc=%08h ecall=%b br=%b next=%08h start=%b cnt=%0d",
               pc, bus.ecall_i, bus.branch_taken_i, bus.pc_next_o, bus.pc_start_o, bus.instr_cnt_o);
  endtask

  // Apply one cycle of inputs away from the clock edge and compare outputs.
  task automatic drive(input logic rst_v, input logic go_v, input logic rdy_v,
                       input logic ec_v, input logic br_v, input logic [31:0] tgt_v);
    @(negedge clk);
    reset               = rst_v;
    bus.go_i            = go_v;
    bus.imem_ready_i    = rdy_v;
    bus.ecall_i         = ec_v;
    bus.branch_taken_i  = br_v;
    bus.branch_target_i = tgt_v;
    bus.pc_i            = pc;
`ifdef PC_SEQ_STEP_EN
    bus.step_i          = 1'b0;
`endif
    #1;
    compare_model();
  endtask

  task automatic tick();
    @(posedge clk);
    if (exp_start) pc = exp_next;
    if (!reset) begin
      m_mode = M_IDLE;
      m_wait = 0;
      m_cnt  = 0;
    end else begin
      case (m_mode)
        M_IDLE: if (bus.go_i) begin m_mode = M_FETCH; m_cnt = 0; m_wait = 0; end
        M_FETCH: begin
          if (bus.imem_ready_i) begin
            m_mode = M_EXEC;
            m_wait = 0;
          end else begin
            m_wait++;
            if (m_wait == TIMEOUT) begin m_mode = M_ERROR; m_wait = 0; end
          end
        end
        M_EXEC: begin
          if (m_cnt < CNT_MAX) m_cnt++;
          m_mode = bus.ecall_i ? M_HALT : M_FETCH;
        end
        M_HALT:  if (bus.go_i) begin m_mode = M_FETCH; m_wait = 0; end
        M_ERROR: if (bus.go_i) m_mode = M_IDLE;
        default: m_mode = M_IDLE;
      endcase
    end
  endtask

  initial begin
    verbose = 1'b1;
    pc      = 32'h0;
    m_mode  = M_IDLE;
    m_wait  = 0;
    m_cnt   = 0;
    exp_start = 1'b0;
    exp_next  = 32'h0;
    reset = 1'b0;

    // Reset for two cycles, then straight-line execution from PC 0.
    drive(0, 0, 0, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 0); tick();
    drive(1, 0, 0, 0, 0, 0);
    chk("rst_busy", bus.busy_o, 0);
    chk("rst_next", bus.pc_next_o, 0);
    tick();
    drive(1, 1, 1, 0, 0, 0); tick();
    for (int k = 1; k <= 3; k++) begin
      drive(1, 0, 1, 0, 0, 0); tick();
      drive(1, 0, 1, 0, 0, 0);
      chk("seq_next", bus.pc_next_o, 4 * k);
      chk("seq_start", bus.pc_start_o, 1);
      tick();
    end
    drive(1, 0, 0, 0, 0, 0);
    chk("seq_cnt", bus.instr_cnt_o, 3);
    tick();

    // Branch redirect with a misaligned target.
    pc = 32'h10;
    drive(1, 0, 1, 0, 0, 0); tick();
    drive(1, 0, 1, 0, 1, 32'h203);
    chk("br_next", bus.pc_next_o, 32'h200);
    chk("br_start", bus.pc_start_o, 1);
    tick();

    // ecall beats branch; HALT then resume past the ecall.
    pc = 32'h40;
    drive(1, 0, 1, 0, 0, 0); tick();
    drive(1, 0, 1, 1, 1, 32'h1234);
    chk("ecall_start", bus.pc_start_o, 0);
    tick();
    drive(1, 0, 0, 0, 0, 0);
    chk("halt_flag", bus.halted_o, 1);
    chk("halt_start", bus.pc_start_o, 0);
    tick();
    drive(1, 1, 0, 0, 0, 0);
    chk("resume_start", bus.pc_start_o, 1);
    chk("resume_next", bus.pc_next_o, 32'h44);
    tick();

    // Fetch timeout: fifteen consecutive not-ready cycles.
    for (int k = 0; k < TIMEOUT; k++) begin
      drive(1, 0, 0, 0, 0, 0);
      chk("to_fetch", bus.fetch_req_o, 1);
      chk("to_start", bus.pc_start_o, 0);
      tick();
    end
    drive(1, 0, 0, 0, 0, 0);
    chk("to_error", bus.error_o, 1);
    tick();
    drive(1, 1, 0, 0, 0, 0);
    chk("to_error_go", bus.error_o, 1);
    tick();
    drive(1, 0, 0, 0, 0, 0);
    chk("err_cleared", bus.error_o, 0);
    chk("err_cnt_kept", bus.instr_cnt_o, 5);
    tick();

    // Ready arriving on the last allowed wait cycle still wins; then PC wrap.
    pc = 32'hFFFF_FFFC;
    drive(1, 1, 0, 0, 0, 0); tick();
    for (int k = 0; k < TIMEOUT - 1; k++) begin
      drive(1, 0, 0, 0, 0, 0); tick();
    end
    drive(1, 0, 1, 0, 0, 0); tick();
    drive(1, 0, 0, 0, 0, 0);
    chk("wait_win_err", bus.error_o, 0);
    chk("wrap_next", bus.pc_next_o, 32'h0);
    chk("wrap_start", bus.pc_start_o, 1);
    tick();

    // Reset in the middle of a fetch.
    drive(0, 0, 0, 0, 0, 0); tick();
    drive(1, 0, 0, 0, 0, 0);
    chk("midrst_fetch", bus.fetch_req_o, 0);
    chk("midrst_cnt", bus.instr_cnt_o, 0);
    tick();

    // Randomized traffic against the model.
    verbose = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      logic rst_v, go_v, rdy_v, ec_v, br_v;
      logic [31:0] tgt_v;
      rst_v = ($urandom_range(0, 199) != 0);
      go_v  = ($urandom_range(0, 3) == 0);
      rdy_v = (n % 400 < 40) ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 9) < 7);
      ec_v  = ($urandom_range(0, 15) == 0);
      br_v  = ($urandom_range(0, 3) == 0);
      tgt_v = $urandom;
      if ($urandom_range(0, 49) == 0) pc = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00} ^ 32'h0;
      drive(rst_v, go_v, rdy_v, ec_v, br_v, tgt_v);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/pc_seq_ctrl.md
Name: pc_seq_ctrl

Overview:
Run-control sequencer for the program counter register.
- Decides each cycle whether the PC advances (drives the PC's start/enable) and what value it loads (drives the PC's next-value input).
- Handles the fetch handshake with instruction memory, branch redirection, ecall halt and a fetch timeout.
- Sits between the PC register, instruction memory and the decode/execute stage.

Parameters:
- XLEN, 32, datapath width of PC and branch target.
- TIMEOUT, 15, max cycles waiting for imem_ready_i before error; 1..255.
- CNT_W, 32, width of retired-instruction counter.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- go_i  in  1  start/restart execution (level, sampled in IDLE/HALT/ERROR).
- pc_i  in  XLEN  current PC value from the PC register.
- fetch_req_o  out  1  instruction fetch request to imem.
- imem_ready_i  in  1  imem has instruction for pc_i valid this cycle.
- ecall_i  in  1  decoded instruction is ecall (valid in EXEC).
- branch_taken_i  in  1  redirect requested (valid in EXEC).
- branch_target_i  in  XLEN  redirect address.
- pc_start_o  out  1  PC load enable (PC start input).
- pc_next_o  out  XLEN  value loaded into PC when pc_start_o=1.
- busy_o  out  1  high in FETCH or EXEC.
- halted_o  out  1  high in HALT.
- error_o  out  1  high in ERROR.
- instr_cnt_o  out  CNT_W  retired instruction count.

Behaviour:
- Reset (reset=0 at rising edge):
  - state=IDLE; timeout counter=0; instr_cnt_o=0.
  - All 1-bit outputs 0; pc_next_o=0.
  - Applies in any state, including mid-FETCH. An outstanding fetch is abandoned; no handshake completion is expected.
- States: IDLE, FETCH, EXEC, HALT, ERROR.
- IDLE:
  - All outputs low.
  - go_i=1 -> FETCH next cycle; instr_cnt_o cleared to 0 on this transition.
- FETCH:
  - fetch_req_o=1, busy_o=1.
  - Each cycle with imem_ready_i=0 increments the wait counter.
  - imem_ready_i=1 -> EXEC next cycle, counter cleared.
  - Counter reaching TIMEOUT with imem_ready_i still 0 -> ERROR.
  - imem_ready_i=1 in the same cycle the counter hits TIMEOUT -> EXEC; ready wins.
- EXEC (exactly 1 cycle), busy_o=1, fetch_req_o=0:
  - ecall_i=1 has priority over branch_taken_i: pc_start_o=0, PC holds the ecall address, instr_cnt_o increments, -> HALT.
  - Otherwise pc_start_o=1 and instr_cnt_o increments, -> FETCH.
  - pc_next_o = branch_taken_i ? {branch_target_i[XLEN-1:2],2'b00} : pc_i+4.
  - Branch target bits [1:0] are forced to 0.
  - pc_i+4 wraps modulo 2^XLEN; 0xFFFFFFFC -> 0x00000000.
- PC update timing: pc_start_o and pc_next_o are combinational in EXEC. The PC register loads at the edge ending EXEC, so the new pc_i is visible in the following FETCH cycle. Latency from imem_ready_i to new PC = 2 edges.
- HALT:
  - halted_o=1; PC frozen.
  - go_i=1 -> FETCH at pc_i+4: one pc_start_o=1 pulse on exit with pc_next_o=pc_i+4. instr_cnt_o not cleared.
- ERROR:
  - error_o=1; PC frozen.
  - go_i=1 -> IDLE; error_o cleared; instr_cnt_o retained.
- instr_cnt_o saturates at all-ones; no wrap.
- pc_start_o is never asserted outside EXEC and the HALT exit cycle.

Optional Feature:
PC_SEQ_STEP_EN.
- Defined:
  - Adds input step_i (1 bit).
  - When step_i=1 in EXEC, the sequencer completes that instruction normally, then goes to IDLE instead of FETCH. ecall still goes to HALT.
  - go_i in IDLE then resumes from the current PC without clearing instr_cnt_o when it is nonzero.
- Not defined: port absent; behaviour exactly as above; IDLE->FETCH always clears instr_cnt_o.

Test Plan:
- Reset held 2 cycles, then go_i pulse with PC=0 and imem_ready_i tied 1 -> pc_next_o sequence 4,8,12 on successive EXEC cycles; instr_cnt_o=3 after third EXEC.
- In EXEC at pc_i=0x10, branch_taken_i=1, branch_target_i=0x203 -> pc_next_o=0x200, pc_start_o=1; next FETCH sees pc_i=0x200.
- ecall_i=1 and branch_taken_i=1 together in EXEC at pc_i=0x40 -> pc_start_o=0, halted_o=1 next cycle, PC stays 0x40. Later go_i=1 -> pc_next_o=0x44 pulse, resumes FETCH.
- imem_ready_i held 0 in FETCH for TIMEOUT=15 cycles -> error_o=1, pc_start_o never asserted. go_i -> IDLE, error_o=0.
- pc_i=0xFFFFFFFC, no branch -> pc_next_o=0x00000000. Also: reset asserted during FETCH -> next cycle all outputs 0, state IDLE.
- (PC_SEQ_STEP_EN) step_i=1 -> exactly one instruction retires per go_i pulse; instr_cnt_o increments 1 per pulse, not cleared.
